md_iter_unit: RTL and testbench
===============================

Name: md_iter_unit

Overview:
Parametrised iterative multiply/divide unit for the EX stage. It executes MIPS-style mult/multu/div/divu on WIDTH-bit operands and returns a {hi, lo} result pair. It uses a valid/ready handshake on both input and output, supports annulment while in flight, and fully defines divide-by-zero and signed-overflow cases. It replaces the separate fixed-width mul/div instances; EX stalls while busy is high.

Parameters:
WIDTH, 32, operand width in bits; any even value >= 4
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden)

Ports:
clk  in  1  rising-edge clock
resetn  in  1  asynchronous active-low reset
op_valid  in  1  operation request
op_ready  out  1  unit can accept an operation (high only in IDLE)
op_code  in  2  00 multu, 01 mult, 10 divu, 11 div
opdata1  in  WIDTH  multiplicand / dividend
opdata2  in  WIDTH  multiplier / divisor
annul  in  1  abort the in-flight operation
res_valid  out  1  result available
res_ready  in  1  consumer takes the result
res_hi  out  WIDTH  mul: product[2W-1:W]; div: remainder
res_lo  out  WIDTH  mul: product[W-1:0]; div: quotient
busy  out  1  high in CALC or DONE
dz  out  1  divide-by-zero flag (present only with the macro; see Optional Feature)

Behaviour:
- Reset (resetn low, asynchronous): state=IDLE, counter=0. op_ready=1, res_valid=0, busy=0, res_hi=res_lo=0, dz=0. Asserting reset mid-operation discards the operation with no result.
- FSM states: IDLE, CALC, DONE.
- IDLE: accept when op_valid&&op_ready (cycle T). Latch op_code and operands. For signed ops, take magnitudes and latch neg_q = sign1^sign2 and neg_r = sign1. Load counter=WIDTH and go to CALC. annul is ignored in IDLE.
- CALC, multiply: shift-add on magnitudes, one multiplier bit per cycle.
- CALC, divide: restoring division on magnitudes, one quotient bit per cycle.
- CALC, counter: decrements each cycle. When counter reaches 1, the next edge applies the sign fix and registers res_hi/res_lo, then goes to DONE.
- Latency: res_valid first high in cycle T+WIDTH+1.
- Sign fix: mult negates the 2W-bit product if neg_q. div negates the quotient if neg_q and the remainder if neg_r. Unsigned ops get no fix.
- Signed overflow: div of -2^(W-1) by -1 gives quotient=-2^(W-1) and remainder=0. The magnitude algorithm produces this naturally, with no trap.
- Divide by zero (opdata2==0, div or divu): res_lo=all ones, res_hi=opdata1 unmodified. No sign fix is applied.
- annul in CALC: next state is IDLE, no result, and res_hi/res_lo keep their previous values. annul in DONE is ignored.
- DONE: res_valid=1, and res_hi/res_lo/dz stay stable until res_valid&&res_ready, then the unit returns to IDLE.
- No overlap: op_ready=0 in DONE, so a new op is accepted no earlier than the cycle after the result handshake.
- Out-of-range op_code cannot occur; all 4 encodings are defined.

Optional Feature:
Macro MD_ITER_DIVZERO_FAST_EN.
- Defined: a divide with opdata2==0 is detected at accept and skips CALC. It goes IDLE->DONE with res_valid in cycle T+1. The dz port exists and is 1 with that result; dz is 0 for every other result and is cleared on handshake.
- Undefined: no dz port. A divide by zero takes the full WIDTH iterations and still yields the defined all-ones / opdata1 result.

Test Plan:
- WIDTH=32, multu 0xFFFFFFFF*0xFFFFFFFF, res_ready=1 -> res_valid in cycle T+33, hi=0xFFFFFFFE, lo=0x00000001, op_ready back the following cycle.
- mult 0xFFFFFFFD(-3)*7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; divu 100/7 -> lo=14, hi=2; div 0xFFFFFFF9(-7)/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0x00000000, no error.
- divu 5/0 -> lo=0xFFFFFFFF, hi=5. With the macro: result in cycle T+1 and dz=1. Without it: result in cycle T+33.
- div accepted, annul pulsed in cycle T+10 -> res_valid never asserts, op_ready=1 in cycle T+11. A following multu 6*7 gives lo=42, hi=0.
- Hold res_ready=0 for 5 cycles after res_valid -> res_hi/res_lo/res_valid stable and op_valid not accepted. Assert resetn=0 mid-CALC -> all outputs immediately at reset values.

Source files
------------

// File: rtl/md_iter_unit.sv
// Iterative multiply/divide unit (multu/mult/divu/div) with valid/ready handshakes and annul.
// Optional macro MD_ITER_DIVZERO_FAST_EN: divide-by-zero bypasses CALC and raises the dz port.
module md_iter_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [1:0]       op_code,
    input  logic [WIDTH-1:0] opdata1,
    input  logic [WIDTH-1:0] opdata2,
    input  logic             annul,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
`ifdef MD_ITER_DIVZERO_FAST_EN
    output logic             dz,
`endif
    output logic             busy
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             is_div_reg, neg_q_reg, neg_r_reg;
    logic [WIDTH-1:0] opnd_reg, acc_hi_reg, acc_lo_reg;
    logic [WIDTH-1:0] res_hi_reg, res_lo_reg;
    logic             op_ready_reg, res_valid_reg, busy_reg;
`ifdef MD_ITER_DIVZERO_FAST_EN
    logic             dz_reg;
`endif

    // Operand magnitudes and sign bits taken at accept
    logic             sign1, sign2, divz;
    logic [WIDTH-1:0] mag1, mag2;

    always_comb begin
        sign1 = op_code[0] & opdata1[WIDTH-1];
        sign2 = op_code[0] & opdata2[WIDTH-1];
        mag1  = sign1 ? -opdata1 : opdata1;
        mag2  = sign2 ? -opdata2 : opdata2;
        divz  = op_code[1] && (opdata2 == '0);
    end

    // One iteration step: multiply uses {acc_hi, acc_lo} as the shifting product,
    // divide uses acc_hi as partial remainder and acc_lo as dividend/quotient.
    logic [WIDTH:0]     mul_sum, div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff, step_hi, step_lo;
    logic [2*WIDTH-1:0] prod_neg;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

    always_comb begin
        mul_sum   = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, opnd_reg} : '0);
        div_shift = {acc_hi_reg, acc_lo_reg[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, opnd_reg};
        div_diff  = div_shift[WIDTH-1:0] - opnd_reg;
        if (is_div_reg) begin
            step_hi = div_ge ? div_diff : div_shift[WIDTH-1:0];
            step_lo = {acc_lo_reg[WIDTH-2:0], div_ge};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo_reg[WIDTH-1:1]};
        end
        prod_neg = -{step_hi, step_lo};
        if (is_div_reg) begin
            fix_hi = neg_r_reg ? -step_hi : step_hi;
            fix_lo = neg_q_reg ? -step_lo : step_lo;
        end else begin
            fix_hi = neg_q_reg ? prod_neg[2*WIDTH-1:WIDTH] : step_hi;
            fix_lo = neg_q_reg ? prod_neg[WIDTH-1:0] : step_lo;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            is_div_reg    <= 1'b0;
            neg_q_reg     <= 1'b0;
            neg_r_reg     <= 1'b0;
            opnd_reg      <= '0;
            acc_hi_reg    <= '0;
            acc_lo_reg    <= '0;
            res_hi_reg    <= '0;
            res_lo_reg    <= '0;
            op_ready_reg  <= 1'b1;
            res_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
`ifdef MD_ITER_DIVZERO_FAST_EN
            dz_reg        <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (op_valid) begin
                        is_div_reg   <= op_code[1];
                        neg_q_reg    <= (sign1 ^ sign2) & ~divz;
                        neg_r_reg    <= op_code[1] & sign1 & ~divz;
                        opnd_reg     <= op_code[1] ? mag2 : mag1;
                        // A zero divisor runs on the raw dividend so the remainder returns it untouched
                        acc_lo_reg   <= op_code[1] ? (divz ? opdata1 : mag1) : mag2;
                        acc_hi_reg   <= '0;
                        cnt_reg      <= CNT_W'(WIDTH);
                        op_ready_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                        state_reg    <= CALC;
`ifdef MD_ITER_DIVZERO_FAST_EN
                        if (divz) begin
                            res_hi_reg    <= opdata1;
                            res_lo_reg    <= '1;
                            res_valid_reg <= 1'b1;
                            dz_reg        <= 1'b1;
                            state_reg     <= DONE;
                        end
`endif
                    end
                end
                CALC: begin
                    if (annul) begin
                        op_ready_reg <= 1'b1;
                        busy_reg     <= 1'b0;
                        state_reg    <= IDLE;
                    end else begin
                        acc_hi_reg <= step_hi;
                        acc_lo_reg <= step_lo;
                        cnt_reg    <= cnt_reg - 1'b1;
                        if (cnt_reg == CNT_W'(1)) begin
                            res_hi_reg    <= fix_hi;
                            res_lo_reg    <= fix_lo;
                            res_valid_reg <= 1'b1;
                            state_reg     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid_reg <= 1'b0;
                        op_ready_reg  <= 1'b1;
                        busy_reg      <= 1'b0;
                        state_reg     <= IDLE;
`ifdef MD_ITER_DIVZERO_FAST_EN
                        dz_reg        <= 1'b0;
`endif
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign op_ready  = op_ready_reg;
    assign res_valid = res_valid_reg;
    assign busy      = busy_reg;
    assign res_hi    = res_hi_reg;
    assign res_lo    = res_lo_reg;
`ifdef MD_ITER_DIVZERO_FAST_EN
    assign dz        = dz_reg;
`endif

endmodule

// File: tb/tb_md_iter_unit.sv
// Randomized bench for md_iter_unit against an arithmetic reference model (WIDTH=32).
module tb_md_iter_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         op_valid = 1'b0;
    logic         annul = 1'b0;
    logic         res_ready = 1'b0;
    logic [1:0]   op_code = '0;
    logic [W-1:0] opdata1 = '0;
    logic [W-1:0] opdata2 = '0;
    logic         op_ready, res_valid, busy;
    logic [W-1:0] res_hi, res_lo;
`ifdef MD_ITER_DIVZERO_FAST_EN
    logic         dz;
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    md_iter_unit #(.WIDTH(W)) dut (
        .clk(clk), .resetn(resetn),
        .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
        .opdata1(opdata1), .opdata2(opdata2), .annul(annul),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_hi(res_hi), .res_lo(res_lo),
`ifdef MD_ITER_DIVZERO_FAST_EN
        .dz(dz),
`endif
        .busy(busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic dz_now();
`ifdef MD_ITER_DIVZERO_FAST_EN
        return dz;
`else
        return 1'b0;
`endif
    endfunction

    // MIPS semantics in plain 64-bit arithmetic
    function automatic void model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] hi, output logic [W-1:0] lo);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = '0;
        hi = '0;
        lo = '0;
        case (op)
            2'b00: begin p = 64'(a) * 64'(b); hi = p[63:32]; lo = p[31:0]; end
            2'b01: begin p = 64'(sa * sb);    hi = p[63:32]; lo = p[31:0]; end
            2'b10: begin
                if (b == 0) begin hi = a; lo = '1; end
                else begin hi = a % b; lo = a / b; end
            end
            default: begin
                if (b == 0) begin hi = a; lo = '1; end
                else begin q = sa / sb; r = sa % sb; hi = W'(r); lo = W'(q); end
            end
        endcase
    endfunction

    task automatic run_op(input string name, input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int hold);
        logic [W-1:0] eh, el;
        int           k;
        bit           fast_dz;
        int           exp_lat;
        model(op, a, b, eh, el);
        fast_dz = FAST && op[1] && (b == 0);
        exp_lat = fast_dz ? 1 : W + 1;
        check({name, " ready_idle"}, op_ready, 1);
        op_valid = 1'b1; op_code = op; opdata1 = a; opdata2 = b; res_ready = 1'b0;
        @(negedge clk);
        op_valid = 1'b0; opdata1 = $urandom; opdata2 = $urandom;
        k = 1;
        check({name, " busy"}, busy, 1);
        while (!res_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        check({name, " latency"}, k, exp_lat);
        check({name, " hi"}, res_hi, eh);
        check({name, " lo"}, res_lo, el);
        check({name, " dz"}, dz_now(), fast_dz);
        for (int i = 0; i < hold; i++) begin
            op_valid = 1'b1; op_code = 2'($urandom);
            @(negedge clk);
            check({name, " hold_valid"}, res_valid, 1);
            check({name, " hold_ready"}, op_ready, 0);
            check({name, " hold_res"}, {res_hi, res_lo}, {eh, el});
        end
        op_valid = 1'b0; res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check({name, " post_valid"}, res_valid, 0);
        check({name, " post_ready"}, op_ready, 1);
        check({name, " post_dz"}, dz_now(), 0);
        $display("op %s code=%0d a=%h b=%h hi=%h lo=%h lat=%0d hold=%0d", name, op, a, b, eh, el, k, hold);
    endtask

    task automatic annul_test();
        logic [W-1:0] ph, pl;
        bit           seen;
        ph = res_hi; pl = res_lo; seen = 1'b0;
        op_valid = 1'b1; op_code = 2'b11; opdata1 = 32'hFFFF1234; opdata2 = 32'd77;
        @(negedge clk);
        op_valid = 1'b0;
        for (int k = 1; k < 10; k++) begin
            seen |= res_valid;
            @(negedge clk);
        end
        annul = 1'b1;
        @(negedge clk);
        annul = 1'b0;
        check("annul op_ready", op_ready, 1);
        check("annul busy", busy, 0);
        check("annul keep", {res_hi, res_lo}, {ph, pl});
        for (int k = 0; k < 40; k++) begin
            seen |= res_valid;
            @(negedge clk);
        end
        check("annul no_result", seen, 0);
        $display("annul div at T+10 hi=%h lo=%h", res_hi, res_lo);
    endtask

    task automatic reset_test();
        op_valid = 1'b1; op_code = 2'b01; opdata1 = 32'h12345678; opdata2 = 32'h9ABCDEF1;
        @(negedge clk);
        op_valid = 1'b0;
        repeat (5) @(negedge clk);
        resetn = 1'b0;
        #1;
        check("rst op_ready", op_ready, 1);
        check("rst res_valid", res_valid, 0);
        check("rst busy", busy, 0);
        check("rst res", {res_hi, res_lo}, 64'd0);
        check("rst dz", dz_now(), 0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        $display("reset mid-CALC");
    endtask

    initial begin
        logic [1:0]   op;
        logic [W-1:0] a, b;
        repeat (2) @(negedge clk);
        check("reset op_ready", op_ready, 1);
        check("reset res_valid", res_valid, 0);
        check("reset busy", busy, 0);
        check("reset res", {res_hi, res_lo}, 64'd0);
        check("reset dz", dz_now(), 0);
        resetn = 1'b1;
        @(negedge clk);

        run_op("multu_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        run_op("mult_neg",  2'b01, 32'hFFFFFFFD, 32'd7, 0);
        run_op("divu",      2'b10, 32'd100, 32'd7, 0);
        run_op("div_neg",   2'b11, 32'hFFFFFFF9, 32'd2, 0);
        run_op("div_ovf",   2'b11, 32'h80000000, 32'hFFFFFFFF, 0);
        run_op("divu_zero", 2'b10, 32'd5, 32'd0, 0);
        run_op("div_zero",  2'b11, 32'hFFFFFF00, 32'd0, 1);
        annul_test();
        run_op("multu_6x7", 2'b00, 32'd6, 32'd7, 0);
        run_op("hold5",     2'b01, 32'h8000_0001, 32'h7FFF_FFFF, 5);
        reset_test();
        run_op("after_rst", 2'b11, 32'h0000_1000, 32'hFFFF_FFF0, 0);

        for (int n = 0; n < 40; n++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 9))
                0: b = '0;
                1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: a = 32'($urandom_range(0, 15));
                default: ;
            endcase
            run_op("rand", op, a, b, $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
